// File: rtl/chopper_pkg.sv
// Shared types and widths for the chopper command executor.
package chopper_pkg;

  // Executor FSM encoding.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  // Command field widths as delivered by the chopper command FIFO.
  localparam int ADDR_W = 64;
  localparam int LEN_W  = 24;

endpackage

// File: rtl/chopper_command_executor_byteenable_gen.sv
// Lane-enable generator: lane i is enabled while more than i bytes remain,
// which yields all ones for a full word and the low lanes for a tail word.
module byteenable_gen
  import chopper_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic [LEN_W-1:0] rem_i,
  output logic [BYTES-1:0] be_o
);

  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    assign be_o[i] = (rem_i > LEN_W'(i));
  end

endmodule

// File: rtl/chopper_command_executor.sv
// Executes chopper block commands as single-word Avalon-MM writes fed from a
// show-ahead source FIFO, pulsing done when the last command completes.
module chopper_command_executor
  import chopper_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    fifo_empty,
  input  logic [ADDR_W-1:0]       fifo_command_address,
  input  logic [LEN_W-1:0]        fifo_command_length,
  input  logic                    fifo_last_command,
  output logic                    fifo_read,
  input  logic                    src_empty,
  input  logic [DATA_WIDTH-1:0]   src_data,
  output logic                    src_read,
  output logic [ADDR_W-1:0]       master_address,
  output logic                    master_write,
  output logic [DATA_WIDTH-1:0]   master_writedata,
  output logic [DATA_WIDTH/8-1:0] master_byteenable,
  input  logic                    master_waitrequest,
  output logic                    busy,
  output logic                    done
);

  localparam int               BYTES   = DATA_WIDTH / 8;
  localparam logic [LEN_W-1:0] BYTES_L = LEN_W'(BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              last_q, last_d;
  logic              pend_q, pend_d;   // word was stalled last cycle: must stay asserted
  logic              done_q, done_d;
  logic              acc, final_w;
  logic [BYTES-1:0]  be_raw;

  assign acc     = master_write & ~master_waitrequest;
  assign final_w = (rem_q <= BYTES_L);

  byteenable_gen #(.BYTES(BYTES)) u_be (
    .rem_i (rem_q),
    .be_o  (be_raw)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: zero-length commands never leave IDLE; WRITE ends on the final
  // accept, or on enable low once no word is outstanding.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fifo_read && fifo_command_length != '0) state_d = ST_WRITE;
      ST_WRITE: if ((acc && (final_w || !enable)) || (!master_write && !enable))
                  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs: a new word is only offered while enabled; a stalled word is held.
  always_comb begin
    fifo_read         = 1'b0;
    master_write      = 1'b0;
    master_address    = '0;
    master_byteenable = '0;
    busy              = 1'b0;
    case (state_q)
      ST_IDLE:  fifo_read = enable & ~fifo_empty & ~reset;
      ST_WRITE: begin
        busy              = 1'b1;
        master_write      = ~src_empty & (enable | pend_q);
        master_address    = addr_q;
        master_byteenable = be_raw;
      end
      default: ;
    endcase
  end

  assign src_read         = acc;
  assign master_writedata = src_data;
  assign done             = done_q;

  // Datapath next state: load on pop, advance on accept.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    last_d = last_q;
    done_d = 1'b0;
    pend_d = master_write & master_waitrequest;
    if (fifo_read) begin
      addr_d = fifo_command_address;
      rem_d  = fifo_command_length;
      last_d = fifo_last_command;
      done_d = (fifo_command_length == '0) & fifo_last_command;
    end else if (acc) begin
      addr_d = addr_q + ADDR_W'(BYTES);
      rem_d  = final_w ? '0 : rem_q - BYTES_L;
      done_d = final_w & last_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      rem_q  <= '0;
      last_q <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      last_q <= last_d;
      pend_q <= pend_d;
      done_q <= done_d;
    end
  end

endmodule

// File: doc/chopper_command_executor.md
# chopper_command_executor

Consumes block commands (address, byte length, last flag) from the command FIFO filled by the transaction chopper. Turns each command into a stream of single-word Avalon-MM write accesses, with data taken from a show-ahead source FIFO. Pulses `done` once the final word of the command flagged last has been accepted by the interconnect. Sits between the command FIFO and the memory master port in the RAM controller test path.

## Interface
- `DATA_WIDTH`, 32: master data width in bits; power of two, 8..512. `BYTES = DATA_WIDTH/8`.
- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level; high allows commands to be fetched and executed.
- `fifo_empty`  in  1  command FIFO empty (show-ahead: fields valid while low).
- `fifo_command_address`  in  64  block byte address; word-aligned.
- `fifo_command_length`  in  24  block length in bytes.
- `fifo_last_command`  in  1  block is the final one of the transfer.
- `fifo_read`  out  1  pops the command FIFO.
- `src_empty`  in  1  data source FIFO empty.
- `src_data`  in  DATA_WIDTH  show-ahead write data.
- `src_read`  out  1  pops the source FIFO.
- `master_address`  out  64  byte address of current word.
- `master_write`  out  1  write request.
- `master_writedata`  out  DATA_WIDTH  equals `src_data`.
- `master_byteenable`  out  BYTES  lane enables.
- `master_waitrequest`  in  1  interconnect stall.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse, registered.

## Operation
- States: IDLE, WRITE.
- IDLE: when `enable & !fifo_empty`, assert `fifo_read` combinationally. In the same edge, latch `addr_r <= fifo_command_address`, `rem_r <= fifo_command_length`, `last_r <= fifo_last_command`, and go to WRITE.
- A zero-length command is popped and stays in IDLE. If its last flag is set, `done` pulses the next cycle.
- WRITE:
  - `master_write = !src_empty`.
  - `master_address = addr_r`.
  - `master_byteenable` = all ones if `rem_r >= BYTES`, else `(1<<rem_r)-1` (low lanes).
- Acceptance is `master_write & !master_waitrequest`. On acceptance:
  - `src_read = 1`.
  - `addr_r += BYTES` (64-bit, wraps modulo 2^64).
  - `rem_r -= BYTES`, saturating at 0.
- Final word of a command: `rem_r <= BYTES`. On its acceptance go to IDLE. If `last_r`, register `done = 1`.
- Avalon hold rule: once `master_write` is asserted, address, data and byteenable stay stable until accepted. `src_empty` cannot rise while a word is pending, because only acceptance pops the source FIFO.
- `enable` low in WRITE:
  - Any word already asserted completes normally.
  - No further word is issued; go to IDLE and discard the remainder of the command. `done` does not pulse.
  - If `master_write` is low at that moment, go to IDLE immediately.
- `fifo_read` is never asserted in WRITE, and never asserted with `fifo_empty` high.

## Timing
- Reset values:
  - state IDLE, `addr_r`/`rem_r`/`last_r` = 0.
  - `fifo_read`, `src_read`, `master_write`, `done`, `busy` = 0.
  - `master_address` = 0, `master_byteenable` = 0 (forced 0 outside WRITE).
- Command pop at cycle N; first `master_write` at N+1 if the source is non-empty.
- Back-to-back words: one per cycle when `waitrequest` is low.
- Command-to-command gap: one IDLE cycle after the final accepted word.
- `done` is high on the cycle after acceptance of the last word of the last command, for exactly one cycle.
- Reset mid-command: return to IDLE asynchronously; all outputs drop in the same instant; the in-flight command is lost.

## Structure
- Package `chopper_pkg`:
  - state encoding constants (IDLE=0, WRITE=1);
  - command field widths (address 64, length 24);
  - shared with `chopper_fsm`.
- One sub-module, `byteenable_gen`: combinational, maps `rem_r` and `BYTES` to `master_byteenable`.

## Test plan
- DATA_WIDTH=32; one command {0x1000, 16, last}; source always full; no waitrequest -> 4 writes at 0x1000/4/8/C, byteenable 0xF, `done` pulses one cycle after the 4th.
- Command {0x2000, 6, last} -> writes at 0x2000 (BE 0xF) and 0x2004 (BE 0x3), then `done`.
- Two commands {0x0, 8, !last} then {0x8, 4, last} -> 3 writes, one IDLE cycle between commands, a single `done` pulse.
- Waitrequest high 3 cycles on the 2nd word -> address/data/BE held stable, `src_read` only on acceptance, total 4 accepts.
- `enable` dropped mid-command while a word is stalled -> that word completes, no further writes, no `done`, state IDLE.
- Reset asserted during WRITE; zero-length last command after release -> outputs 0 at once; zero-length command pops with no writes, `done` pulses.
